// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forward-select codes and the result-source encoding for loads.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    // x0 is hardwired to zero, so a write to it never produces a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one E-stage source register.
// The M stage has priority because it holds the younger result.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && reg_match(rd_m, rs_e)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && reg_match(rd_w, rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch flushes,
// multi-cycle MDU stall with timeout, and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rs1_e,
    input  logic [4:0]        rs2_e,
    input  logic [4:0]        rd_e,
    input  logic [1:0]        res_src_e,
    input  logic [4:0]        rd_m,
    input  logic [4:0]        rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mdu_start_e,
    input  logic              mdu_done,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              mdu_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [BW-1:0] BUSY_LAST = BW'(MDU_TIMEOUT - 1);

    hz_state_t     state, state_nxt;
    logic [BW-1:0] busy_cnt, busy_cnt_nxt;
    logic          err_set;
    logic          lu;
    logic [1:0]    fwd_a, fwd_b;

    hazard_fwd_unit u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_b)
    );

    assign forward_a_e = rst ? FWD_RF : fwd_a;
    assign forward_b_e = rst ? FWD_RF : fwd_b;

    assign lu = (res_src_e == RES_SRC_LOAD) &&
                (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            busy_cnt <= '0;
            mdu_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            if (err_set) begin
                mdu_err <= 1'b1;
            end
        end
    end

    // Branch beats MDU start beats load-use; while the MDU is busy the whole
    // front end is frozen, so branches and load-use in E are simply held.
    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        err_set      = 1'b0;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pc_src_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (mdu_start_e) begin
                        stall_f      = 1'b1;
                        stall_d      = 1'b1;
                        stall_e      = 1'b1;
                        flush_m      = 1'b1;
                        busy_cnt_nxt = '0;
                        state_nxt    = ST_MDU_BUSY;
                    end else if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_done) begin
                        state_nxt = ST_RUN;
                    end else if (busy_cnt == BUSY_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        stall_f      = 1'b1;
                        stall_d      = 1'b1;
                        stall_e      = 1'b1;
                        flush_m      = 1'b1;
                        busy_cnt_nxt = busy_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations
// into a queue, and a monitor compares them at each falling edge.
module tb_hazard_ctrl;

    localparam int MDU_TIMEOUT = 8;
    localparam int CNT_W       = 4;

    // Control-vector order: stall_f stall_d stall_e flush_d flush_e flush_m mdu_err
    localparam logic [6:0] NONE  = 7'b000_000_0;
    localparam logic [6:0] RSTF  = 7'b000_111_0;
    localparam logic [6:0] LUS   = 7'b110_010_0;
    localparam logic [6:0] BRF   = 7'b000_110_0;
    localparam logic [6:0] MDU   = 7'b111_001_0;
    localparam logic [6:0] ERR   = 7'b000_000_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]       res_src_e;
    logic             reg_write_m, reg_write_w, pc_src_e, mdu_start_e, mdu_done;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_err;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [6:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MDU_TIMEOUT (MDU_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .res_src_e   (res_src_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .pc_src_e    (pc_src_e),
        .mdu_start_e (mdu_start_e),
        .mdu_done    (mdu_done),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_m     (flush_m),
        .mdu_err     (mdu_err),
        .stall_cnt   (stall_cnt)
    );

    function automatic obs_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic [6:0] ctl, input int cnt);
        obs_t o;
        o.fa  = fa;
        o.fb  = fb;
        o.ctl = ctl;
        o.cnt = CNT_W'(cnt);
        return o;
    endfunction

    task automatic clearInputs();
        rst         = 1'b0;
        rs1_d       = '0;
        rs2_d       = '0;
        rs1_e       = '0;
        rs2_e       = '0;
        rd_e        = '0;
        res_src_e   = '0;
        rd_m        = '0;
        rd_w        = '0;
        reg_write_m = 1'b0;
        reg_write_w = 1'b0;
        pc_src_e    = 1'b0;
        mdu_start_e = 1'b0;
        mdu_done    = 1'b0;
    endtask

    // Advance one cycle and return the inputs to an idle vector.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic pushExpected(input string name, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input string name, input obs_t e);
        obs_t act;
        act = {forward_a_e, forward_b_e,
               stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_err,
               stall_cnt};
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s: got fa=%b fb=%b ctl=%b cnt=%0d, expected fa=%b fb=%b ctl=%b cnt=%0d",
                     name, act.fa, act.fb, act.ctl, act.cnt, e.fa, e.fb, e.ctl, e.cnt);
        end
    endtask

    // Monitor: outputs are valid every cycle, so compare one queued entry per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checkOutput(name_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    initial begin
        clearInputs();
        rst = 1'b1;

        applyStimulus(); rst = 1'b1; rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 1'b1;
        pushExpected("reset", mk(2'b00, 2'b00, RSTF, 0));

        applyStimulus(); rs1_e = 5; rd_m = 5; reg_write_m = 1'b1; rd_w = 5; reg_write_w = 1'b1;
        pushExpected("fwd_a_m", mk(2'b10, 2'b00, NONE, 0));

        applyStimulus(); rs1_e = 5; rd_m = 0; reg_write_m = 1'b1; rd_w = 5; reg_write_w = 1'b1;
        pushExpected("fwd_a_w", mk(2'b01, 2'b00, NONE, 0));

        applyStimulus(); rs2_e = 3; rd_m = 3; reg_write_m = 1'b1; rd_w = 3; reg_write_w = 1'b1;
        pushExpected("fwd_b_m_over_w", mk(2'b00, 2'b10, NONE, 0));

        applyStimulus(); rs1_e = 4; rs2_e = 4; rd_m = 4; rd_w = 4; reg_write_w = 1'b1;
        pushExpected("fwd_m_wen_off", mk(2'b01, 2'b01, NONE, 0));

        applyStimulus(); reg_write_m = 1'b1; reg_write_w = 1'b1;
        pushExpected("fwd_x0", mk(2'b00, 2'b00, NONE, 0));

        applyStimulus(); rs1_e = 6; rs2_e = 2; rd_m = 2; reg_write_m = 1'b1; rd_w = 6; reg_write_w = 1'b1;
        pushExpected("fwd_mixed", mk(2'b01, 2'b10, NONE, 0));

        applyStimulus(); res_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        pushExpected("load_use_rs2", mk(2'b00, 2'b00, LUS, 0));

        applyStimulus();
        pushExpected("after_lu", mk(2'b00, 2'b00, NONE, 1));

        applyStimulus(); res_src_e = 2'b01; rd_e = 0; rs1_d = 0;
        pushExpected("lu_x0", mk(2'b00, 2'b00, NONE, 1));

        applyStimulus(); res_src_e = 2'b10; rd_e = 7; rs1_d = 7;
        pushExpected("lu_not_load", mk(2'b00, 2'b00, NONE, 1));

        applyStimulus(); res_src_e = 2'b01; rd_e = 9; rs1_d = 9;
        pushExpected("load_use_rs1", mk(2'b00, 2'b00, LUS, 1));

        applyStimulus();
        pushExpected("after_lu_rs1", mk(2'b00, 2'b00, NONE, 2));

        applyStimulus(); res_src_e = 2'b01; rd_e = 7; rs2_d = 7; pc_src_e = 1'b1;
        pushExpected("branch_over_lu", mk(2'b00, 2'b00, BRF, 2));

        applyStimulus();
        pushExpected("after_branch", mk(2'b00, 2'b00, NONE, 2));

        applyStimulus(); mdu_start_e = 1'b1;
        pushExpected("mdu_start", mk(2'b00, 2'b00, MDU, 2));

        applyStimulus();
        pushExpected("busy1", mk(2'b00, 2'b00, MDU, 3));

        applyStimulus(); pc_src_e = 1'b1;
        pushExpected("busy_ignores_branch", mk(2'b00, 2'b00, MDU, 4));

        applyStimulus(); res_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        pushExpected("busy_ignores_lu", mk(2'b00, 2'b00, MDU, 5));

        applyStimulus();
        pushExpected("busy4", mk(2'b00, 2'b00, MDU, 6));

        applyStimulus(); mdu_done = 1'b1;
        pushExpected("mdu_done_release", mk(2'b00, 2'b00, NONE, 7));

        applyStimulus();
        pushExpected("run_after_done", mk(2'b00, 2'b00, NONE, 7));

        applyStimulus(); mdu_done = 1'b1;
        pushExpected("done_in_run", mk(2'b00, 2'b00, NONE, 7));

        applyStimulus(); mdu_start_e = 1'b1;
        pushExpected("timeout_start", mk(2'b00, 2'b00, MDU, 7));

        for (int i = 0; i < MDU_TIMEOUT - 1; i++) begin
            applyStimulus();
            pushExpected($sformatf("timeout_busy%0d", i), mk(2'b00, 2'b00, MDU, 8 + i));
        end

        applyStimulus();
        pushExpected("timeout_release", mk(2'b00, 2'b00, NONE, 15));

        applyStimulus();
        pushExpected("err_sticky", mk(2'b00, 2'b00, NONE | ERR, 15));

        applyStimulus(); mdu_done = 1'b1;
        pushExpected("done_in_run_err", mk(2'b00, 2'b00, NONE | ERR, 15));

        applyStimulus(); res_src_e = 2'b01; rd_e = 7; rs1_d = 7;
        pushExpected("lu_at_max", mk(2'b00, 2'b00, LUS | ERR, 15));

        applyStimulus();
        pushExpected("cnt_saturated", mk(2'b00, 2'b00, NONE | ERR, 15));

        applyStimulus(); mdu_start_e = 1'b1;
        pushExpected("mdu_start2", mk(2'b00, 2'b00, MDU | ERR, 15));

        applyStimulus();
        pushExpected("busy_sat", mk(2'b00, 2'b00, MDU | ERR, 15));

        applyStimulus(); rst = 1'b1; rs1_e = 5; rd_m = 5; reg_write_m = 1'b1;
        pushExpected("rst_in_busy", mk(2'b00, 2'b00, RSTF | ERR, 15));

        applyStimulus();
        pushExpected("after_rst", mk(2'b00, 2'b00, NONE, 0));

        applyStimulus(); res_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        pushExpected("run_after_rst_lu", mk(2'b00, 2'b00, LUS, 0));

        applyStimulus();
        pushExpected("cnt_after_rst", mk(2'b00, 2'b00, NONE, 1));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
